// File: rtl/ahb_slave_mux.sv
// AHB-Lite single-master interconnect: base/mask address decode, data-phase
// mux, built-in ERROR default slave, stalled-slave watchdog and error log.
module ahb_slave_mux #(
  parameter int NUM_SLAVES     = 5,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
    {32'h8000_1000, 32'h1000_1000, 32'h1000_0000, 32'h0C00_0000, 32'h0200_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFC00_0000, 32'hFFFF_0000},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            CPU_HADDR,
  input  logic [1:0]                       CPU_HTRANS,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_HRDATA,
  input  logic [NUM_SLAVES-1:0]            S_HREADY,
  input  logic [NUM_SLAVES*2-1:0]          S_HRESP,
  output logic [NUM_SLAVES-1:0]            HSEL,
  output logic [DATA_WIDTH-1:0]            CPU_HRDATA,
  output logic                             CPU_HREADY,
  output logic [1:0]                       CPU_HRESP,
  output logic                             err_pulse,
  output logic [15:0]                      err_count,
  output logic [ADDR_WIDTH-1:0]            err_addr
);

  localparam int DSEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLAVE,
    ST_DEF1,
    ST_DEF2,
    ST_TO1,
    ST_TO2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [DSEL_W-1:0]     r_dsel;
  logic [ADDR_WIDTH-1:0] r_haddrDp;
  logic [WD_W-1:0]       r_wdCnt;
  logic [15:0]           r_errCount;
  logic [ADDR_WIDTH-1:0] r_errAddr;

  logic                  w_hit;
  logic [DSEL_W-1:0]     w_hitIdx;
  logic [DATA_WIDTH-1:0] w_slvData;
  logic                  w_slvReady;
  logic [1:0]            w_slvResp;

  // Scanning from the top index down leaves the lowest matching slave as winner.
  always_comb begin
    w_hit    = 1'b0;
    w_hitIdx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((CPU_HADDR & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_hit    = 1'b1;
        w_hitIdx = DSEL_W'(i);
      end
    end
  end

  always_comb begin
    HSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL[i] = w_hit && (w_hitIdx == DSEL_W'(i));
    end
  end

  always_comb begin
    w_slvData  = '0;
    w_slvReady = 1'b1;
    w_slvResp  = RESP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_dsel == DSEL_W'(i)) begin
        w_slvData  = S_HRDATA[i*DATA_WIDTH +: DATA_WIDTH];
        w_slvReady = S_HREADY[i];
        w_slvResp  = S_HRESP[i*2 +: 2];
      end
    end
  end

  // Any cycle presenting HREADY high also accepts the next address phase.
  always_comb begin
    w_nextState = r_state;
    CPU_HRDATA  = '0;
    CPU_HREADY  = 1'b1;
    CPU_HRESP   = RESP_OKAY;
    err_pulse   = 1'b0;
    case (r_state)
      ST_IDLE: begin
      end
      ST_SLAVE: begin
        CPU_HRDATA = w_slvData;
        CPU_HREADY = w_slvReady;
        CPU_HRESP  = w_slvResp;
        if (!w_slvReady && (TIMEOUT_CYCLES > 0) && (r_wdCnt == WD_LAST)) begin
          w_nextState = ST_TO1;
        end
      end
      ST_DEF1: begin
        CPU_HREADY  = 1'b0;
        CPU_HRESP   = RESP_ERROR;
        w_nextState = ST_DEF2;
      end
      ST_TO1: begin
        CPU_HREADY  = 1'b0;
        CPU_HRESP   = RESP_ERROR;
        w_nextState = ST_TO2;
      end
      ST_DEF2, ST_TO2: begin
        CPU_HRESP = RESP_ERROR;
        err_pulse = 1'b1;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
    if (CPU_HREADY) begin
      if (!CPU_HTRANS[1]) begin
        w_nextState = ST_IDLE;
      end else if (w_hit) begin
        w_nextState = ST_SLAVE;
      end else begin
        w_nextState = ST_DEF1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dsel     <= '0;
      r_haddrDp  <= '0;
      r_wdCnt    <= '0;
      r_errCount <= '0;
      r_errAddr  <= '0;
    end else begin
      r_state <= w_nextState;
      if (CPU_HREADY) begin
        r_dsel    <= w_hitIdx;
        r_haddrDp <= CPU_HADDR;
        r_wdCnt   <= '0;
      end else if ((r_state == ST_SLAVE) && !w_slvReady) begin
        r_wdCnt <= r_wdCnt + WD_W'(1);
      end
      // Only interconnect-generated errors reach here; slave ERRORs never pulse.
      if (err_pulse) begin
        if (r_errCount != 16'hFFFF) begin
          r_errCount <= r_errCount + 16'd1;
        end
        r_errAddr <= r_haddrDp;
      end
    end
  end

  assign err_count = r_errCount;
  assign err_addr  = r_errAddr;

endmodule

// File: doc/ahb_slave_mux.md
# ahb_slave_mux

Parametrised AHB-Lite single-master interconnect that replaces the fixed five-slave SoC decoder. It decodes the CPU address phase into NUM_SLAVES one-hot selects from a per-slave base/mask map and registers the data-phase owner. It multiplexes slave read data and responses back to the CPU. Unlike its predecessor, it adds a built-in default slave (two-cycle ERROR for unmapped addresses), a stalled-slave watchdog, and error bookkeeping.

## Interface
Parameters:
- NUM_SLAVES, 5, number of slave ports (1..16)
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HRDATA width
- SLV_BASE, {CLINT, PLIC, UART, SPI, DTUBE bases}, packed NUM_SLAVES*ADDR_WIDTH; slave i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- SLV_MASK, per-slave region masks, same packing as SLV_BASE
- TIMEOUT_CYCLES, 256, stalled data-phase cycles before forced ERROR; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- CPU_HADDR  in  ADDR_WIDTH  master address
- CPU_HTRANS  in  2  master transfer type; bit1=1 means NONSEQ/SEQ
- S_HRDATA  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
- S_HREADY  in  NUM_SLAVES  slave HREADYOUT
- S_HRESP  in  NUM_SLAVES*2  packed slave responses
- HSEL  out  NUM_SLAVES  one-hot address-phase select
- CPU_HRDATA  out  DATA_WIDTH  muxed read data
- CPU_HREADY  out  1  muxed ready; also fed back to slaves as HREADY
- CPU_HRESP  out  2  muxed response (OKAY=2'b00, ERROR=2'b01)
- err_pulse  out  1  one-cycle pulse when an interconnect-generated ERROR completes
- err_count  out  16  saturating count of interconnect-generated ERRORs
- err_addr  out  ADDR_WIDTH  address of the most recent interconnect-generated ERROR

## Operation
- Decode: hit_i = ((CPU_HADDR & SLV_MASK_i) == SLV_BASE_i).
- On overlapping hits, the lowest index wins. HSEL carries that one-hot and is not gated by HTRANS. No hit gives HSEL = 0.
- Address-phase acceptance: a cycle with CPU_HREADY=1.
- On acceptance, the data-phase state, owner index dsel and address haddr_dp are loaded:
  - HTRANS[1]=0: go to IDLE.
  - Hit: go to SLAVE with dsel = winning index.
  - No hit: go to DEF1.
- States and outputs:
  - IDLE: CPU_HREADY=1, CPU_HRESP=OKAY, CPU_HRDATA=0.
  - SLAVE: CPU_HRDATA/CPU_HREADY/CPU_HRESP = slave dsel's signals. Slave ERROR two-cycle responses pass through untouched.
  - DEF1/TO1: CPU_HREADY=0, CPU_HRESP=ERROR, CPU_HRDATA=0. Always advance to DEF2/TO2.
  - DEF2/TO2: CPU_HREADY=1, CPU_HRESP=ERROR, CPU_HRDATA=0. err_pulse=1. A new address phase is accepted in this cycle.
- Watchdog (TIMEOUT_CYCLES>0):
  - wd_cnt clears on every acceptance and increments each SLAVE cycle with S_HREADY[dsel]=0.
  - When wd_cnt==TIMEOUT_CYCLES-1 and S_HREADY[dsel]=0, go to TO1. The slave transfer is abandoned and its later HREADY is ignored.
  - If S_HREADY[dsel]=1 in that same cycle, the transfer completes normally and no timeout fires.
- Bookkeeping, on the cycle err_pulse=1:
  - err_count increments, saturating at 16'hFFFF.
  - err_addr loads haddr_dp.
  - Slave-originated ERRORs are not counted.

## Timing
- HSEL is combinational from CPU_HADDR with zero latency. The data-phase mux switches the cycle after acceptance.
- Unmapped access completes 2 cycles after acceptance: ERROR with HREADY low, then ERROR with HREADY high.
- Timeout: the first TO1 cycle is the (TIMEOUT_CYCLES+1)-th data-phase cycle, followed by the TO2 cycle.
- Reset values: state=IDLE, so CPU_HREADY=1, CPU_HRESP=OKAY, CPU_HRDATA=0. Also dsel=0, wd_cnt=0, err_pulse=0, err_count=0, err_addr=0. HSEL stays combinational.
- A reset asserted mid-transfer, including in DEF1/TO1, returns to IDLE next cycle with no err_pulse and no count change.
- Back-to-back: after a SLAVE completion or DEF2/TO2, the next accepted transfer owns the data phase on the following cycle with no bubble.

## Test plan
- Map slave 2 base 0x1000_0000 mask 0xF000_0000; NONSEQ read 0x1000_0004; slave 2 returns 0xDEADBEEF, HREADY=1, OKAY -> HSEL=5'b00100 in the address cycle; CPU_HRDATA=0xDEADBEEF, OKAY, HREADY=1 the next cycle.
- NONSEQ to unmapped 0xF000_0000 -> HSEL=0; then HREADY=0/ERROR, HREADY=1/ERROR; err_pulse=1, err_count=1, err_addr=0xF000_0000.
- TIMEOUT_CYCLES=4, slave 1 holds HREADY=0 -> 4 stall cycles, then TO1/TO2 ERROR; err_count increments; slave raising HREADY later has no effect.
- TIMEOUT_CYCLES=4, slave 1 raises HREADY exactly on the 4th stall cycle -> normal OKAY completion, no err_pulse.
- Overlapping slaves 0 and 3 on the same region -> HSEL=0001; slave 0 data returned.
- rst asserted during DEF1 -> next cycle HREADY=1, OKAY, err_count unchanged; IDLE transfers (HTRANS=00) -> OKAY with zero wait.
